io_timer_array: RTL and testbench

- Parametrised multi-channel bus timer, successor to the single io_timer slave on the demux bus.
- Provides CHANNELS independent down-counters, each WIDTH bits wide, all driven from one shared programmable prescaler.
- Each channel runs one-shot or periodic and can raise a maskable interrupt.
- Interrupts from all channels are combined onto the shared active-low nIRQ line; the block sits behind the address decoder like the other io_* slaves.

---
 rtl/io_timer_array_pkg.sv | 40 ++++
 rtl/io_timer_array_if.sv | 22 ++
 rtl/io_timer_array_timer_channel.sv | 117 +++++++++++
 rtl/io_timer_array.sv | 141 ++++++++++++++
 tb/tb_io_timer_array.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/io_timer_array_pkg.sv
// io_timer_pkg: shared constants and types for the io_timer_array slave.
// Holds the register offsets within each address block, the CTRL bit
// positions, the CTRL field struct and a helper that extracts CTRL from bus data.
// No ports (package).
package io_timer_pkg;

  localparam int DATA_W = 16;

  // Offsets inside a channel block
  localparam logic [1:0] CTRL_OFS     = 2'd0;
  localparam logic [1:0] RELOAD_OFS   = 2'd1;
  localparam logic [1:0] COUNT_OFS    = 2'd2;
  localparam logic [1:0] CAPTURE_OFS  = 2'd3;

  // Offsets inside the global block
  localparam logic [1:0] STATUS_OFS   = 2'd0;
  localparam logic [1:0] PRESCALE_OFS = 2'd1;

  // CTRL bit positions
  localparam int CTRL_EN_BIT       = 0;
  localparam int CTRL_PERIODIC_BIT = 1;
  localparam int CTRL_IRQEN_BIT    = 2;
  localparam int CTRL_W            = 3;

  typedef struct packed {
    logic irqEn;
    logic periodic;
    logic en;
  } ctrl_t;

  // Pull the CTRL fields out of a bus write word.
  function automatic ctrl_t unpackCtrl(input logic [DATA_W-1:0] d);
    ctrl_t c;
    c.en       = d[CTRL_EN_BIT];
    c.periodic = d[CTRL_PERIODIC_BIT];
    c.irqEn    = d[CTRL_IRQEN_BIT];
    return c;
  endfunction

endpackage

// File: rtl/io_timer_array_if.sv
// io_timer_array_if: demux-bus slave interface for io_timer_array.
// Signals:
//   nSel    - active-low slave select from the address decoder
//   write   - one-cycle write strobe, qualified by nSel=0
//   addr    - word address (ADDR_W bits)
//   dataIn  - write data
//   dataOut - read data driven by the slave
// Modports: master (CPU/decoder side), slave (timer side).
interface io_timer_array_if
  import io_timer_pkg::*;
#(
  parameter int ADDR_W = 5
);
  logic              nSel;
  logic              write;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] dataIn;
  logic [DATA_W-1:0] dataOut;

  modport master (output nSel, write, addr, dataIn, input dataOut);
  modport slave  (input nSel, write, addr, dataIn, output dataOut);
endinterface

// File: rtl/io_timer_array_timer_channel.sv
// timer_channel: one down-counter channel of io_timer_array.
// Holds CTRL, RELOAD, COUNT (and CAPTURE when enabled) and the expiry logic.
// Optional feature macro: TIMER_CAPTURE_EN (capture synchroniser + latch).
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   i_tick       - one-cycle prescaler tick
//   i_ctrlWr     - write strobe for CTRL
//   i_reloadWr   - write strobe for RELOAD
//   i_wrData     - bus write data
//   i_capture    - raw asynchronous capture strobe
//   o_ctrl       - current CTRL fields
//   o_reload     - RELOAD register
//   o_count      - COUNT register
//   o_capture    - CAPTURE register (0 without TIMER_CAPTURE_EN)
//   o_event      - one-cycle pulse that sets this channel's pending bit
module timer_channel
  import io_timer_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_tick,
  input  logic              i_ctrlWr,
  input  logic              i_reloadWr,
  input  logic [DATA_W-1:0] i_wrData,
  input  logic              i_capture,
  output ctrl_t             o_ctrl,
  output logic [WIDTH-1:0]  o_reload,
  output logic [WIDTH-1:0]  o_count,
  output logic [WIDTH-1:0]  o_capture,
  output logic              o_event
);

  ctrl_t            r_ctrl;
  logic [WIDTH-1:0] r_reload;
  logic [WIDTH-1:0] r_count;
  ctrl_t            w_newCtrl;
  logic             w_expire;

  assign w_newCtrl = unpackCtrl(i_wrData);
  assign w_expire  = r_ctrl.en & i_tick & (r_count == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_reload <= '0;
    end else if (i_reloadWr) begin
      r_reload <= i_wrData[WIDTH-1:0];
    end
  end

  // A CTRL write owns EN and COUNT for its cycle; an expiry on that same
  // edge still reaches the pending bit through o_event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ctrl  <= '0;
      r_count <= '0;
    end else if (i_ctrlWr) begin
      r_ctrl <= w_newCtrl;
      if (!r_ctrl.en && w_newCtrl.en) begin
        r_count <= r_reload;
      end
    end else if (r_ctrl.en && i_tick) begin
      if (r_count == '0) begin
        if (r_ctrl.periodic) begin
          r_count <= r_reload;
        end else begin
          r_ctrl.en <= 1'b0;
        end
      end else begin
        r_count <= r_count - WIDTH'(1);
      end
    end
  end

`ifdef TIMER_CAPTURE_EN
  logic [1:0]       r_sync;
  logic             r_syncD;
  logic [WIDTH-1:0] r_capture;
  logic             w_capEvent;

  // Two-flop synchroniser plus a delayed copy for rising-edge detection:
  // input edge -> CAPTURE updated takes three clock edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync  <= '0;
      r_syncD <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_capture};
      r_syncD <= r_sync[1];
    end
  end

  assign w_capEvent = r_sync[1] & ~r_syncD & r_ctrl.en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_capture <= '0;
    end else if (w_capEvent) begin
      r_capture <= r_count;
    end
  end

  assign o_capture = r_capture;
  assign o_event   = w_expire | w_capEvent;
`else
  logic w_unusedCapture;
  assign w_unusedCapture = i_capture;
  assign o_capture       = '0;
  assign o_event         = w_expire;
`endif

  assign o_ctrl   = r_ctrl;
  assign o_reload = r_reload;
  assign o_count  = r_count;

endmodule

// File: rtl/io_timer_array.sv
// io_timer_array: multi-channel bus timer slave on the demux bus.
// CHANNELS down-counters share one programmable prescaler; expiries set
// pending bits in STATUS (write-1-to-clear) and drive the registered,
// active-low interrupt line.
// Optional feature macro: TIMER_CAPTURE_EN (per-channel capture inputs).
// Ports:
//   clk        - system clock
//   rst        - asynchronous active-high reset
//   bus        - io_timer_array_if slave (nSel, write, addr, dataIn, dataOut)
//   i_capture  - per-channel capture strobes (ignored without the macro)
//   o_nIrq     - registered active-low interrupt
module io_timer_array
  import io_timer_pkg::*;
#(
  parameter int CHANNELS   = 4,
  parameter int WIDTH      = 16,
  parameter int PRESCALE_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  io_timer_array_if.slave     bus,
  input  logic [CHANNELS-1:0] i_capture,
  output logic                o_nIrq
);

  localparam int ADDR_W = $clog2(CHANNELS + 1) + 2;
  localparam int BLK_W  = ADDR_W - 2;

  logic                  w_wr;
  logic [BLK_W-1:0]      w_blk;
  logic [1:0]            w_ofs;
  logic                  w_isGlobal;
  logic                  w_tick;
  logic                  w_prescaleWr;
  logic                  w_statusWr;
  logic [CHANNELS-1:0]   w_clrMask;
  logic [CHANNELS-1:0]   w_event;
  logic [CHANNELS-1:0]   w_irqEn;
  logic [CHANNELS-1:0]   w_ctrlWr;
  logic [CHANNELS-1:0]   w_reloadWr;
  ctrl_t                 w_ctrl    [CHANNELS];
  logic [WIDTH-1:0]      w_reload  [CHANNELS];
  logic [WIDTH-1:0]      w_count   [CHANNELS];
  logic [WIDTH-1:0]      w_capture [CHANNELS];

  logic [PRESCALE_W-1:0] r_prescale;
  logic [PRESCALE_W-1:0] r_preCnt;
  logic [CHANNELS-1:0]   r_pending;
  logic                  r_nIrq;

  assign w_wr         = ~bus.nSel & bus.write;
  assign w_blk        = bus.addr[ADDR_W-1:2];
  assign w_ofs        = bus.addr[1:0];
  assign w_isGlobal   = (w_blk == BLK_W'(CHANNELS));
  assign w_prescaleWr = w_wr & w_isGlobal & (w_ofs == PRESCALE_OFS);
  assign w_statusWr   = w_wr & w_isGlobal & (w_ofs == STATUS_OFS);
  assign w_clrMask    = w_statusWr ? bus.dataIn[CHANNELS-1:0] : '0;

  genvar k;
  generate
    for (k = 0; k < CHANNELS; k++) begin : g_chan
      assign w_ctrlWr[k]   = w_wr & (w_blk == BLK_W'(k)) & (w_ofs == CTRL_OFS);
      assign w_reloadWr[k] = w_wr & (w_blk == BLK_W'(k)) & (w_ofs == RELOAD_OFS);
      assign w_irqEn[k]    = w_ctrl[k].irqEn;

      timer_channel #(
        .WIDTH (WIDTH)
      ) u_chan (
        .clk        (clk),
        .rst        (rst),
        .i_tick     (w_tick),
        .i_ctrlWr   (w_ctrlWr[k]),
        .i_reloadWr (w_reloadWr[k]),
        .i_wrData   (bus.dataIn),
        .i_capture  (i_capture[k]),
        .o_ctrl     (w_ctrl[k]),
        .o_reload   (w_reload[k]),
        .o_count    (w_count[k]),
        .o_capture  (w_capture[k]),
        .o_event    (w_event[k])
      );
    end
  endgenerate

  // Prescaler counts down to 0, ticks for that one cycle, then reloads.
  // A PRESCALE write restarts the count from the new value.
  assign w_tick = (r_preCnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prescale <= '0;
      r_preCnt   <= '0;
    end else if (w_prescaleWr) begin
      r_prescale <= bus.dataIn[PRESCALE_W-1:0];
      r_preCnt   <= bus.dataIn[PRESCALE_W-1:0];
    end else if (w_tick) begin
      r_preCnt   <= r_prescale;
    end else begin
      r_preCnt   <= r_preCnt - PRESCALE_W'(1);
    end
  end

  // Set beats clear when a W1C hits the same cycle as a new event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending <= '0;
      r_nIrq    <= 1'b1;
    end else begin
      r_pending <= (r_pending & ~w_clrMask) | w_event;
      r_nIrq    <= ~|(r_pending & w_irqEn);
    end
  end

  assign o_nIrq = r_nIrq;

  // Read mux: combinational from addr while selected, zero otherwise.
  always_comb begin
    bus.dataOut = '0;
    if (!bus.nSel) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (w_blk == BLK_W'(i)) begin
          case (w_ofs)
            CTRL_OFS:    bus.dataOut = DATA_W'(w_ctrl[i]);
            RELOAD_OFS:  bus.dataOut = DATA_W'(w_reload[i]);
            COUNT_OFS:   bus.dataOut = DATA_W'(w_count[i]);
            CAPTURE_OFS: bus.dataOut = DATA_W'(w_capture[i]);
            default:     bus.dataOut = '0;
          endcase
        end
      end
      if (w_isGlobal) begin
        case (w_ofs)
          STATUS_OFS:   bus.dataOut = DATA_W'(r_pending);
          PRESCALE_OFS: bus.dataOut = DATA_W'(r_prescale);
          default:      bus.dataOut = '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_io_timer_array.sv
// tb_io_timer_array: self-checking bench for io_timer_array
// (CHANNELS=4, WIDTH=16, PRESCALE_W=8, so ADDR_W=5; global block at 16).
// Expected CAPTURE behaviour follows the TIMER_CAPTURE_EN macro.
`timescale 1ns/1ps
module tb_io_timer_array;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] capture = '0;
  logic       nIrq;

  int testsRun    = 0;
  int testsFailed = 0;

  io_timer_array_if #(.ADDR_W(5)) bus ();

  io_timer_array #(
    .CHANNELS   (4),
    .WIDTH      (16),
    .PRESCALE_W (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .i_capture (capture),
    .o_nIrq    (nIrq)
  );

  always #10 clk = ~clk;

`ifdef TIMER_CAPTURE_EN
  localparam logic [15:0] CAP_EXP    = 16'd100;
  localparam logic [15:0] CAP_STATUS = 16'h0008;
`else
  localparam logic [15:0] CAP_EXP    = 16'd0;
  localparam logic [15:0] CAP_STATUS = 16'h0000;
`endif

  typedef struct {
    logic [4:0]  wAddr;
    logic [15:0] wData;
    logic [4:0]  rAddr;
    logic [15:0] expData;
  } wrVec_t;

  typedef struct {
    logic [15:0] reload;
    int          expPeriod;
  } periodVec_t;

  wrVec_t     wrTable [10];
  periodVec_t perTable [4];

  // Compare and log one result.
  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
    end
  endtask

  // Bus write; returns 1ns after the write edge.
  task automatic applyStimulus(input logic [4:0] a, input logic [15:0] d);
    bus.nSel   = 1'b0;
    bus.write  = 1'b1;
    bus.addr   = a;
    bus.dataIn = d;
    @(posedge clk);
    #1;
    bus.nSel   = 1'b1;
    bus.write  = 1'b0;
  endtask

  task automatic readReg(input logic [4:0] a, output logic [15:0] d);
    bus.nSel  = 1'b0;
    bus.write = 1'b0;
    bus.addr  = a;
    #1;
    d = bus.dataOut;
    bus.nSel  = 1'b1;
  endtask

  task automatic checkReg(input string name, input logic [4:0] a, input logic [15:0] exp);
    logic [15:0] d;
    readReg(a, d);
    checkOutput(name, d, exp);
  endtask

  task automatic stepCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyReset();
    rst = 1'b1;
    #5;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] d;
    int hits [4];
    int firstHit [4];
    int secondHit [4];

    wrTable[0] = '{5'd1,  16'hABCD, 5'd1,  16'hABCD};
    wrTable[1] = '{5'd13, 16'h0001, 5'd13, 16'h0001};
    wrTable[2] = '{5'd4,  16'hFFFE, 5'd4,  16'h0006};
    wrTable[3] = '{5'd10, 16'h5555, 5'd10, 16'h0000};
    wrTable[4] = '{5'd11, 16'h1234, 5'd11, 16'h0000};
    wrTable[5] = '{5'd17, 16'hFF12, 5'd17, 16'h0012};
    wrTable[6] = '{5'd18, 16'hFFFF, 5'd18, 16'h0000};
    wrTable[7] = '{5'd28, 16'hFFFF, 5'd28, 16'h0000};
    wrTable[8] = '{5'd16, 16'hFFFF, 5'd16, 16'h0000};
    wrTable[9] = '{5'd0,  16'h0000, 5'd1,  16'hABCD};

    perTable[0] = '{16'd1, 4};
    perTable[1] = '{16'd2, 6};
    perTable[2] = '{16'd3, 8};
    perTable[3] = '{16'd4, 10};

    bus.nSel   = 1'b1;
    bus.write  = 1'b0;
    bus.addr   = '0;
    bus.dataIn = '0;

    // Reset state: every address reads 0, nIRQ high, DataOut 0 when deselected.
    applyReset();
    checkOutput("reset nIrq", {15'd0, nIrq}, 16'd1);
    checkOutput("reset dataOut deselected", bus.dataOut, 16'd0);
    for (int a = 0; a < 32; a++) begin
      readReg(5'(a), d);
      checkOutput($sformatf("reset read addr %0d", a), d, 16'd0);
      stepCycles(1);
    end

    // Register write/readback table.
    applyReset();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(wrTable[i].wAddr, wrTable[i].wData);
      readReg(wrTable[i].rAddr, d);
      checkOutput($sformatf("wrvec %0d", i), d, wrTable[i].expData);
    end

    // Counting, RELOAD write while running, stop/freeze, async reset mid-count.
    applyReset();
    applyStimulus(5'd1, 16'd100);
    applyStimulus(5'd17, 16'd1);
    applyStimulus(5'd0, 16'h0001);
    stepCycles(9);
    checkReg("count after 5 ticks", 5'd2, 16'd95);
    applyStimulus(5'd1, 16'd7);
    checkReg("count after reload write", 5'd2, 16'd95);
    stepCycles(1);
    checkReg("count keeps decrementing", 5'd2, 16'd94);
    applyStimulus(5'd0, 16'h0000);
    stepCycles(4);
    checkReg("count frozen by EN=0", 5'd2, 16'd94);
    applyStimulus(5'd4, 16'h0007);
    stepCycles(3);
    checkOutput("ch1 reload0 nIrq low", {15'd0, nIrq}, 16'd0);
    checkReg("ch1 reload0 pending", 5'd16, 16'h0002);
    #3;
    rst = 1'b1;
    #2;
    checkOutput("async reset nIrq", {15'd0, nIrq}, 16'd1);
    checkReg("async reset count", 5'd2, 16'd0);
    checkReg("async reset status", 5'd16, 16'd0);
    checkReg("async reset reload", 5'd1, 16'd0);
    rst = 1'b0;
    stepCycles(1);

    // One-shot with PRESCALE=3: expiry on the 6th tick, EN clears.
    applyReset();
    applyStimulus(5'd1, 16'd5);
    applyStimulus(5'd17, 16'd3);
    applyStimulus(5'd0, 16'h0005);
    stepCycles(22);
    checkReg("oneshot not yet pending", 5'd16, 16'h0000);
    stepCycles(1);
    checkReg("oneshot pending", 5'd16, 16'h0001);
    checkOutput("oneshot nIrq still high", {15'd0, nIrq}, 16'd1);
    stepCycles(1);
    checkOutput("oneshot nIrq low", {15'd0, nIrq}, 16'd0);
    checkReg("oneshot EN cleared", 5'd0, 16'h0004);
    checkReg("oneshot count stays 0", 5'd2, 16'd0);
    applyStimulus(5'd16, 16'h0001);
    checkOutput("oneshot nIrq after clear edge", {15'd0, nIrq}, 16'd0);
    stepCycles(1);
    checkOutput("oneshot nIrq released", {15'd0, nIrq}, 16'd1);

    // Periodic ch1 every 3 cycles; W1C colliding with expiry keeps pending.
    applyReset();
    applyStimulus(5'd5, 16'd2);
    applyStimulus(5'd4, 16'h0003);
    stepCycles(2);
    checkReg("periodic before expiry", 5'd16, 16'h0000);
    stepCycles(1);
    checkReg("periodic first expiry", 5'd16, 16'h0002);
    applyStimulus(5'd16, 16'h0002);
    checkReg("periodic cleared", 5'd16, 16'h0000);
    stepCycles(1);
    checkReg("periodic still clear", 5'd16, 16'h0000);
    stepCycles(1);
    checkReg("periodic second expiry", 5'd16, 16'h0002);
    applyStimulus(5'd16, 16'h0002);
    checkReg("periodic cleared again", 5'd16, 16'h0000);
    stepCycles(1);
    checkReg("periodic clear before collision", 5'd16, 16'h0000);
    applyStimulus(5'd16, 16'h0002);
    checkReg("set wins over W1C", 5'd16, 16'h0002);
    checkReg("periodic EN kept", 5'd4, 16'h0003);
    checkReg("periodic reloaded", 5'd6, 16'd2);

    // IRQEN masking on ch2.
    applyReset();
    applyStimulus(5'd9, 16'd1);
    applyStimulus(5'd8, 16'h0001);
    stepCycles(2);
    checkReg("masked pending", 5'd16, 16'h0004);
    checkOutput("masked nIrq high", {15'd0, nIrq}, 16'd1);
    checkReg("ch2 EN cleared", 5'd8, 16'h0000);
    applyStimulus(5'd8, 16'h0004);
    checkOutput("irqen edge nIrq", {15'd0, nIrq}, 16'd1);
    stepCycles(1);
    checkOutput("irqen nIrq low", {15'd0, nIrq}, 16'd0);
    applyStimulus(5'd16, 16'h0004);
    checkOutput("w1c edge nIrq", {15'd0, nIrq}, 16'd0);
    checkReg("w1c status", 5'd16, 16'h0000);
    stepCycles(1);
    checkOutput("w1c nIrq high", {15'd0, nIrq}, 16'd1);

    // All channels periodic, PRESCALE=1: period = (RELOAD+1)*2 each.
    applyReset();
    for (int c = 0; c < 4; c++) begin
      applyStimulus(5'(c * 4 + 1), perTable[c].reload);
      hits[c] = 0;
      firstHit[c] = 0;
      secondHit[c] = 0;
    end
    applyStimulus(5'd17, 16'd1);
    for (int c = 0; c < 4; c++) begin
      applyStimulus(5'(c * 4), 16'h0003);
    end
    for (int cyc = 0; cyc < 80; cyc++) begin
      readReg(5'd16, d);
      for (int c = 0; c < 4; c++) begin
        if (d[c]) begin
          if (hits[c] == 0) firstHit[c] = cyc;
          else if (hits[c] == 1) secondHit[c] = cyc;
          hits[c]++;
        end
      end
      applyStimulus(5'd16, d);
    end
    for (int c = 0; c < 4; c++) begin
      if (hits[c] < 2) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL period ch%0d: got %0d expiries, expected at least 2", c, hits[c]);
      end else begin
        checkOutput($sformatf("period ch%0d", c), 16'(secondHit[c] - firstHit[c]),
                    16'(perTable[c].expPeriod));
      end
    end
    checkOutput("period nIrq unmasked none", {15'd0, nIrq}, 16'd1);

    // Capture on ch3 while COUNT is held at 100 by a long prescale.
    applyReset();
    applyStimulus(5'd13, 16'd100);
    applyStimulus(5'd17, 16'd255);
    applyStimulus(5'd12, 16'h0001);
    capture[3] = 1'b1;
    stepCycles(2);
    checkReg("capture not yet", 5'd15, 16'd0);
    stepCycles(1);
    checkReg("capture value", 5'd15, CAP_EXP);
    checkReg("capture pending", 5'd16, CAP_STATUS);
    capture[3] = 1'b0;
    checkReg("capture count held", 5'd14, 16'd100);
    stepCycles(2);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
